// File: rtl/pwm_decoder_pkg.sv
// Shared types and defaults for the PWM decoder.
// Holds the FSM state encoding and the default counter width / stuck timeout.
package pwm_decoder_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_RISE = 2'd0,
        ST_HIGH      = 2'd1,
        ST_LOW       = 2'd2,
        ST_STUCK     = 2'd3
    } state_e;

    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a third flop for edge detection.
// Ports: clk, rst_n (sync, active-low), d (async in); level, rise, fall (1-cycle pulses).
module sync_edge_det
    import pwm_decoder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_decoder.sv
// PWM decoder: measures high time and rising-to-rising period of pwm_in, flags stuck input.
// Ports: clk, rst_n, ena, pwm_in; high_cnt, period_cnt, valid, stuck_high, stuck_low.
module pwm_decoder
    import pwm_decoder_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);

    logic lvl, rise, fall;
    logic idle_hit;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hi_ctr_q, hi_ctr_d;
    logic [CNT_W-1:0] per_ctr_q, per_ctr_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic             valid_q, valid_d;
    logic             stuck_high_q, stuck_high_d;
    logic             stuck_low_q, stuck_low_d;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pwm_in),
        .level (lvl),
        .rise  (rise),
        .fall  (fall)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    always_comb begin
        state_d      = state_q;
        hi_ctr_d     = hi_ctr_q;
        per_ctr_d    = per_ctr_q;
        idle_d       = (rise || fall) ? '0 : sat_inc(idle_q);
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        valid_d      = 1'b0;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;
        idle_hit     = (idle_d == TO);

        if (!ena) begin
            state_d   = ST_WAIT_RISE;
            hi_ctr_d  = '0;
            per_ctr_d = '0;
            idle_d    = '0;
        end else begin
            unique case (state_q)
                ST_WAIT_RISE: begin
                    if (rise) begin
                        state_d      = ST_HIGH;
                        hi_ctr_d     = ONE;
                        per_ctr_d    = ONE;
                        stuck_high_d = 1'b0;
                        stuck_low_d  = 1'b0;
                    end else if (fall) begin
                        stuck_high_d = 1'b0;
                        stuck_low_d  = 1'b0;
                    end else if (idle_hit) begin
                        stuck_high_d = lvl;
                        stuck_low_d  = ~lvl;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        // The fall cycle belongs to the low phase.
                        state_d   = ST_LOW;
                        per_ctr_d = sat_inc(per_ctr_q);
                    end else if (idle_hit) begin
                        state_d      = ST_STUCK;
                        stuck_high_d = lvl;
                        stuck_low_d  = ~lvl;
                    end else begin
                        hi_ctr_d  = sat_inc(hi_ctr_q);
                        per_ctr_d = sat_inc(per_ctr_q);
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state_d      = ST_HIGH;
                        high_cnt_d   = hi_ctr_q;
                        period_cnt_d = per_ctr_q;
                        valid_d      = 1'b1;
                        hi_ctr_d     = ONE;
                        per_ctr_d    = ONE;
                    end else if (idle_hit) begin
                        state_d      = ST_STUCK;
                        stuck_high_d = lvl;
                        stuck_low_d  = ~lvl;
                    end else begin
                        per_ctr_d = sat_inc(per_ctr_q);
                    end
                end
                ST_STUCK: begin
                    if (rise) begin
                        state_d      = ST_HIGH;
                        hi_ctr_d     = ONE;
                        per_ctr_d    = ONE;
                        stuck_high_d = 1'b0;
                        stuck_low_d  = 1'b0;
                    end else if (fall) begin
                        state_d      = ST_WAIT_RISE;
                        hi_ctr_d     = '0;
                        per_ctr_d    = '0;
                        stuck_high_d = 1'b0;
                        stuck_low_d  = 1'b0;
                    end
                end
                default: state_d = ST_WAIT_RISE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT_RISE;
            hi_ctr_q     <= '0;
            per_ctr_q    <= '0;
            idle_q       <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            valid_q      <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_ctr_q     <= hi_ctr_d;
            per_ctr_q    <= per_ctr_d;
            idle_q       <= idle_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            valid_q      <= valid_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign valid      = valid_q;
    assign stuck_high = stuck_high_q;
    assign stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder: a 16-bit and an 8-bit instance share one stimulus.
// A timestamp-based reference model predicts each report; a monitor pops and compares.
`timescale 1ns/1ps
module tb_pwm_decoder;

    localparam int W0 = 16;
    localparam int T0 = 1024;
    localparam int W1 = 8;
    localparam int T1 = 250;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic pwm_in;

    logic [W0-1:0] hc0, pc0;
    logic          v0, sh0, sl0;
    logic [W1-1:0] hc1, pc1;
    logic          v1, sh1, sl1;

    always #5 clk = ~clk;

    pwm_decoder #(.CNT_W(W0), .TIMEOUT(T0)) u0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .pwm_in     (pwm_in),
        .high_cnt   (hc0),
        .period_cnt (pc0),
        .valid      (v0),
        .stuck_high (sh0),
        .stuck_low  (sl0)
    );

    pwm_decoder #(.CNT_W(W1), .TIMEOUT(T1)) u1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .pwm_in     (pwm_in),
        .high_cnt   (hc1),
        .period_cnt (pc1),
        .valid      (v1),
        .stuck_high (sh1),
        .stuck_low  (sl1)
    );

    typedef struct {
        int stamp;
        int hi;
        int per;
    } rep_t;

    rep_t q0[$];
    rep_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int valids = 0;

    // Input reaches the decoder logic two clocks after it is sampled.
    logic [2:0] dly = 3'b000;

    int ref_t[2];
    int fall_t[2];
    int clr_t[2];
    int out_h[2];
    int out_p[2];
    bit m_sh[2];
    bit m_sl[2];
    int maxv[2] = '{65535, 255};
    int tmo[2]  = '{T0, T1};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int sat(input int i, input int x);
        return (x > maxv[i]) ? maxv[i] : x;
    endfunction

    task automatic push(input int i, input rep_t r);
        if (i == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    task automatic model_step();
        logic lv, pv, rs, fl;
        rep_t r;
        cyc++;
        lv  = dly[1];
        pv  = dly[2];
        rs  = lv & ~pv;
        fl  = ~lv & pv;
        dly = rst_n ? {dly[1:0], pwm_in} : 3'b000;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                ref_t[i]  = -1;
                fall_t[i] = -1;
                clr_t[i]  = cyc;
                m_sh[i]   = 1'b0;
                m_sl[i]   = 1'b0;
                out_h[i]  = 0;
                out_p[i]  = 0;
            end else if (!ena) begin
                ref_t[i] = -1;
                clr_t[i] = cyc;
            end else if (rs) begin
                if (ref_t[i] >= 0) begin
                    r.stamp  = cyc;
                    r.hi     = sat(i, fall_t[i] - ref_t[i]);
                    r.per    = sat(i, cyc - ref_t[i]);
                    out_h[i] = r.hi;
                    out_p[i] = r.per;
                    push(i, r);
                end
                ref_t[i] = cyc;
                clr_t[i] = cyc;
                m_sh[i]  = 1'b0;
                m_sl[i]  = 1'b0;
            end else if (fl) begin
                fall_t[i] = cyc;
                clr_t[i]  = cyc;
                m_sh[i]   = 1'b0;
                m_sl[i]   = 1'b0;
            end else if (cyc - clr_t[i] == tmo[i]) begin
                m_sh[i]  = lv;
                m_sl[i]  = ~lv;
                ref_t[i] = -1;
            end
        end
    endtask

    task automatic mon(input int i, input logic v, input int hc, input int pc,
                       input logic sh, input logic sl);
        rep_t r;
        bit   have;
        have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) r = (i == 0) ? q0[0] : q1[0];
        if (v) begin
            valids++;
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid[%0d] @cyc %0d: got valid=1, expected 0", i, cyc);
            end else begin
                if (i == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
                check($sformatf("valid_cycle[%0d]", i), cyc, r.stamp);
                check($sformatf("rep_high[%0d]", i), hc, r.hi);
                check($sformatf("rep_period[%0d]", i), pc, r.per);
            end
        end else if (have && r.stamp <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_valid[%0d] @cyc %0d: got valid=0, expected 1", i, cyc);
            if (i == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
        end
        check($sformatf("high_cnt[%0d]", i), hc, out_h[i]);
        check($sformatf("period_cnt[%0d]", i), pc, out_p[i]);
        check($sformatf("stuck_high[%0d]", i), int'(sh), int'(m_sh[i]));
        check($sformatf("stuck_low[%0d]", i), int'(sl), int'(m_sl[i]));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        mon(0, v0, int'(hc0), int'(pc0), sh0, sl0);
        mon(1, v1, int'(hc1), int'(pc1), sh1, sl1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic period(input int hi, input int per);
        pwm_in = 1'b1;
        tick(hi);
        pwm_in = 1'b0;
        tick(per - hi);
    endtask

    task automatic broken(input bit use_rst);
        pwm_in = 1'b1;
        tick(10);
        if (use_rst) rst_n = 1'b0;
        else ena = 1'b0;
        tick(3);
        rst_n = 1'b1;
        ena   = 1'b1;
        tick(10);
        pwm_in = 1'b0;
        tick(44);
    endtask

    initial begin
        int per, hi;
        rst_n  = 1'b0;
        ena    = 1'b0;
        pwm_in = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(2);
        ena = 1'b1;

        repeat (6) period(6, 64);
        repeat (5) period(32, 64);

        pwm_in = 1'b0;
        tick(1100);
        repeat (4) period(6, 64);

        pwm_in = 1'b1;
        tick(2000);
        pwm_in = 1'b0;
        tick(30);

        repeat (4) period(100, 300);
        repeat (3) period(6, 64);

        broken(1'b0);
        repeat (3) period(6, 64);
        broken(1'b1);
        repeat (3) period(6, 64);

        repeat (40) begin
            per = $urandom_range(400, 3);
            hi  = $urandom_range(per - 1, 1);
            period(hi, per);
        end

        pwm_in = 1'b0;
        tick(20);

        check("pending_reports[0]", q0.size(), 0);
        check("pending_reports[1]", q1.size(), 0);
        check("enough_valids", int'(valids > 40), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 Parameter CNT_W, default 16, width of the high-time and period counters and their outputs.
REQ-002 Parameter TIMEOUT, default 1024, clock cycles without a detected edge before the stuck condition is declared; legal range 2 to 2^CNT_W-1.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 ena  input  1  block enable; 0 forces state WAIT_RISE with counters cleared; outputs hold their last values.
REQ-006 pwm_in  input  1  asynchronous PWM waveform under measurement.
REQ-007 high_cnt  output  CNT_W  high time, in clk cycles, of the last complete PWM period.
REQ-008 period_cnt  output  CNT_W  rising-to-rising length, in clk cycles, of the last complete PWM period.
REQ-009 valid  output  1  one-cycle pulse when high_cnt/period_cnt update.
REQ-010 stuck_high  output  1  level; pwm_in has been high for at least TIMEOUT cycles.
REQ-011 stuck_low  output  1  level; pwm_in has been low for at least TIMEOUT cycles.

Function
REQ-012 pwm_in passes through a 2-flop synchronizer; a third flop provides the edge detection: rise = s2 & ~s3, fall = ~s2 & s3.
REQ-013 Rise and fall are each asserted exactly one cycle per synchronized transition; pwm_in pulses shorter than one clk period need not be detected.
REQ-014 FSM states: WAIT_RISE (no period reference yet), HIGH, LOW, STUCK.
REQ-015 WAIT_RISE --rise--> HIGH; both counters load 1.
REQ-016 HIGH: hi_ctr and per_ctr increment each cycle; on fall, go to LOW with hi_ctr frozen.
REQ-017 LOW: per_ctr increments each cycle; on rise, latch high_cnt<=hi_ctr and period_cnt<=per_ctr, pulse valid in that same cycle, reload both counters to 1, go to HIGH.
REQ-018 Consequently a 64-cycle period with 6 cycles high yields high_cnt=6 and period_cnt=64.
REQ-019 The first valid is issued at the second detected rise after WAIT_RISE; the partial first period is never reported.
REQ-020 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-021 An edge-idle counter clears on every rise or fall and otherwise increments, saturating; when it reaches TIMEOUT in HIGH or LOW, go to STUCK and set stuck_high=s2 and stuck_low=~s2.
REQ-022 In WAIT_RISE the same idle counter sets stuck_low or stuck_high identically while staying in WAIT_RISE.
REQ-023 STUCK or WAIT_RISE with a stuck flag set: the next rise clears both stuck flags and enters HIGH with counters at 1 (no valid); a fall clears both flags and enters WAIT_RISE.
REQ-024 stuck_high and stuck_low are never both 1.
REQ-025 When ena falls mid-period: no valid is issued; the FSM enters WAIT_RISE on the next cycle; the synchronizer keeps running.

Reset
REQ-026 While rst_n=0 at a clk edge: state=WAIT_RISE; all counters, high_cnt, period_cnt, valid, stuck_high and stuck_low become 0; synchronizer flops become 0.
REQ-027 Reset asserted mid-period discards the partial measurement; the first valid after release follows REQ-019.

Structure
REQ-028 A package pwm_decoder_pkg holds the state enumeration and the CNT_W/TIMEOUT default constants.
REQ-029 Synchronizer plus edge detector is one sub-module, sync_edge_det (inputs clk, rst_n, d; outputs level, rise, fall).

Verification
REQ-030 PWM with period 64 and 6 high, ena=1 -> after the second rise, valid pulses every 64 cycles with high_cnt=6 and period_cnt=64.
REQ-031 Duty changes from 6 to 32 mid-stream -> exactly one transitional report, then high_cnt=32 and period_cnt=64.
REQ-032 pwm_in held 0 for 1100 cycles, TIMEOUT=1024 -> stuck_low=1 at idle count 1024, valid silent; a following rise clears stuck_low and the next valid appears one period later.
REQ-033 pwm_in held 1 for 2000 cycles -> stuck_high=1 and stuck_low=0.
REQ-034 CNT_W=8 with a 300-cycle period -> period_cnt=255 (saturated), no wrap.
REQ-035 rst_n=0 or ena=0 for 3 cycles mid-HIGH -> no valid from the broken period; outputs match REQ-026 (reset case); the first valid comes at the second rise afterwards.
